// File: rtl/fifo_pkg.sv
// Shared constants for the dual-clock FIFO read side: default widths and
// skid-buffer occupancy encodings.
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int OCC_W      = 2;

  typedef logic [OCC_W-1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_TWO   = 2'd2;

  // Occupancy the buffer will have next cycle, widened so the issue check
  // can never wrap.
  function automatic logic [2:0] occ_after(input occ_t occ, input logic add,
                                           input logic sub);
    return {1'b0, occ} + {2'b0, add} - {2'b0, sub};
  endfunction
endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry buffer absorbing the FIFO read latency; buf0 is always the head
// word and is presented directly downstream.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int Data_width = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [Data_width-1:0] wr_data,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [Data_width-1:0] rd_data,
  output occ_t                  occ
);
  logic [Data_width-1:0] buf0, buf1;
  logic [Data_width-1:0] buf0_n, buf1_n;
  occ_t                  occ_mid, occ_n;
  logic                  pop;

  assign rd_valid = (occ != OCC_EMPTY);
  assign rd_data  = buf0;
  assign pop      = rd_valid & rd_ready;

  always_comb begin
    buf0_n  = buf0;
    buf1_n  = buf1;
    occ_mid = occ - {1'b0, pop};
    occ_n   = occ_mid + {1'b0, wr_valid};
    if (pop)
      buf0_n = buf1;
    // The incoming word lands at the tail as seen after this cycle's pop.
    if (wr_valid) begin
      if (occ_mid == OCC_EMPTY)
        buf0_n = wr_data;
      else
        buf1_n = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ  <= OCC_EMPTY;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      occ  <= occ_n;
      buf0 <= buf0_n;
      buf1 <= buf1_n;
    end
  end
endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-side drain engine: pops the FIFO, buffers the one-cycle read latency
// and streams words downstream on valid/ready, counting delivered words.
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int Data_width  = DATA_WIDTH,
  parameter int Count_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   En,
  input  logic                   Fifo_empty,
  output logic                   Fifo_rd_en,
  input  logic [Data_width-1:0]  Fifo_rd_data,
  output logic                   Out_valid,
  input  logic                   Out_ready,
  output logic [Data_width-1:0]  Out_data,
  output logic [Count_width-1:0] Word_cnt
);
  occ_t occ;
  logic inflight;
  logic pop;

  assign pop = Out_valid & Out_ready;

  // Out_ready feeds the pop request combinationally so a draining buffer can
  // keep one word per clock flowing.
  assign Fifo_rd_en = rst & En & ~Fifo_empty &
                      (occ_after(occ, inflight, pop) < 3'd2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight <= 1'b0;
      Word_cnt <= '0;
    end else begin
      inflight <= Fifo_rd_en;
      if (pop)
        Word_cnt <= Word_cnt + {{(Count_width-1){1'b0}}, 1'b1};
    end
  end

  rd_skid_buf #(
    .Data_width (Data_width)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (inflight),
    .wr_data  (Fifo_rd_data),
    .rd_ready (Out_ready),
    .rd_valid (Out_valid),
    .rd_data  (Out_data),
    .occ      (occ)
  );
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench: a behavioural FIFO feeds the streamer; delivered words are
// checked in order against the loaded sequence, plus latency and flow control.
module tb_fifo_rd_streamer;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, En, Fifo_empty, Out_ready;
  logic [7:0]  Fifo_rd_data;
  logic        Fifo_rd_en, Out_valid;
  logic [7:0]  Out_data;
  logic [15:0] Word_cnt;

  logic        Fifo_empty4, Out_ready4, En4;
  logic [7:0]  Fifo_rd_data4;
  logic        Fifo_rd_en4, Out_valid4;
  logic [7:0]  Out_data4;
  logic [3:0]  Word_cnt4;

  fifo_rd_streamer #(.Data_width(8), .Count_width(16)) dut (
    .clk(clk), .rst(rst), .En(En), .Fifo_empty(Fifo_empty),
    .Fifo_rd_en(Fifo_rd_en), .Fifo_rd_data(Fifo_rd_data),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_data(Out_data),
    .Word_cnt(Word_cnt)
  );

  fifo_rd_streamer #(.Data_width(8), .Count_width(4)) dut4 (
    .clk(clk), .rst(rst), .En(En4), .Fifo_empty(Fifo_empty4),
    .Fifo_rd_en(Fifo_rd_en4), .Fifo_rd_data(Fifo_rd_data4),
    .Out_valid(Out_valid4), .Out_ready(Out_ready4), .Out_data(Out_data4),
    .Word_cnt(Word_cnt4)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  fq[$];
  logic [7:0]  exp_q[$];
  logic        pend;
  logic [7:0]  pend_data;
  int          rem4;
  logic        sv_valid, sv_rd_en, sv_valid4;
  logic [7:0]  sv_data, sv_data4;
  logic [15:0] sv_cnt;
  logic [3:0]  sv_cnt4;
  logic        mon, stall_seen;
  int          viol;
  logic [2:0]  fill, max_fill;
  logic [15:0] lfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load(input logic [7:0] d);
    fq.push_back(d);
    exp_q.push_back(d);
    Fifo_empty = 1'b0;
  endtask

  // One clock: sample and score at the falling edge, update the FIFO model
  // just after the rising edge.
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    #1;
    sv_valid  = Out_valid;
    sv_data   = Out_data;
    sv_rd_en  = Fifo_rd_en;
    sv_cnt    = Word_cnt;
    sv_valid4 = Out_valid4;
    sv_data4  = Out_data4;
    sv_cnt4   = Word_cnt4;
    if (Fifo_rd_en) begin
      if (fq.size() == 0)
        chk("pop_while_empty", 32'(fq.size()), 1);
      else begin
        pend      = 1'b1;
        pend_data = fq.pop_front();
      end
    end
    if (Out_valid && Out_ready) begin
      if (exp_q.size() == 0)
        chk("extra_word", 32'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(Out_data), 32'(e));
      end
    end
    if (mon) begin
      fill = {1'b0, dut.occ} + {2'b0, dut.inflight};
      if (fill > max_fill) max_fill = fill;
      if (!Out_ready && fill == 3'd2) begin
        stall_seen = 1'b1;
        if (Fifo_rd_en) viol++;
      end
    end
    if (Fifo_rd_en4 && rem4 > 0) rem4--;
    @(posedge clk);
    #1;
    if (pend) begin
      Fifo_rd_data = pend_data;
      pend = 1'b0;
    end
    Fifo_empty  = (fq.size() == 0);
    Fifo_empty4 = (rem4 == 0);
  endtask

  task automatic drain(input string tag, input int budget, input logic rnd);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || sv_valid) && n < budget) begin
      if (rnd) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        Out_ready = lfsr[0];
      end
      step();
      n++;
    end
    Out_ready = 1'b1;
    chk({tag, "_done"}, 32'(exp_q.size()), 0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, bubbles, n;
    rst = 1'b0; En = 1'b1; Fifo_empty = 1'b1; Out_ready = 1'b1;
    Fifo_rd_data = 8'h00; En4 = 1'b1; Fifo_empty4 = 1'b1; Out_ready4 = 1'b1;
    Fifo_rd_data4 = 8'h00; rem4 = 0; pend = 1'b0; mon = 1'b0;
    stall_seen = 1'b0; viol = 0; fill = '0; max_fill = '0; lfsr = 16'hACE1;
    sv_valid = 1'b0;

    // Reset state
    repeat (3) step();
    chk("reset_valid", 32'(sv_valid), 0);
    chk("reset_data", 32'(sv_data), 0);
    chk("reset_cnt", 32'(sv_cnt), 0);
    chk("reset_rd_en", 32'(sv_rd_en), 0);
    chk("reset_cnt4", 32'(sv_cnt4), 0);
    rst = 1'b1;

    // Reset while the first pop is in flight
    for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i));
    step();
    chk("mid_rst_first_pop", 32'(sv_rd_en), 1);
    rst = 1'b0;
    step();
    chk("mid_rst_rd_en", 32'(sv_rd_en), 0);
    chk("mid_rst_valid", 32'(sv_valid), 0);
    rst = 1'b1;
    void'(exp_q.pop_front());
    step();
    chk("mid_rst_after_valid", 32'(sv_valid), 0);
    chk("mid_rst_after_cnt", 32'(sv_cnt), 0);
    drain("mid_rst", 100, 1'b0);
    chk("mid_rst_cnt", 32'(sv_cnt), 4);

    // Empty FIFO never popped
    bad = 0;
    repeat (20) begin
      step();
      if (sv_rd_en || sv_valid) bad++;
    end
    chk("empty_idle", 32'(bad), 0);

    // Two-word latency
    load(8'h4D); load(8'hFF);
    step();
    chk("lat_pop0", 32'(sv_rd_en), 1);
    chk("lat_valid0", 32'(sv_valid), 0);
    step();
    chk("lat_valid1", 32'(sv_valid), 0);
    step();
    chk("lat_valid2", 32'(sv_valid), 1);
    chk("lat_data2", 32'(sv_data), 32'h4D);
    step();
    chk("lat_valid3", 32'(sv_valid), 1);
    chk("lat_data3", 32'(sv_data), 32'hFF);
    step();
    chk("lat_valid4", 32'(sv_valid), 0);
    chk("lat_cnt", 32'(sv_cnt), 6);

    // Full-rate drain
    for (int i = 0; i < 32; i++) load(8'h4D + 8'(i));
    n = 0;
    while (!sv_valid && n < 10) begin step(); n++; end
    chk("full_first_valid", 32'(sv_valid), 1);
    bubbles = 0;
    for (int i = 1; i < 32; i++) begin
      step();
      if (!sv_valid) bubbles++;
    end
    chk("full_bubbles", 32'(bubbles), 0);
    step();
    chk("full_end_valid", 32'(sv_valid), 0);
    chk("full_cnt", 32'(sv_cnt), 38);
    chk("full_exp_empty", 32'(exp_q.size()), 0);

    // Random backpressure
    for (int i = 0; i < 32; i++) load(8'h10 + 8'(i));
    mon = 1'b1; max_fill = '0; viol = 0; stall_seen = 1'b0;
    drain("bp", 600, 1'b1);
    mon = 1'b0;
    chk("bp_no_pop_when_full", 32'(viol), 0);
    chk("bp_stall_seen", 32'(stall_seen), 1);
    chk("bp_fill_le2", 32'(max_fill <= 3'd2), 1);
    chk("bp_cnt", 32'(sv_cnt), 70);

    // Enable dropped mid-burst, then resumed
    for (int i = 0; i < 16; i++) load(8'h60 + 8'(i));
    repeat (5) step();
    En = 1'b0;
    bad = 0;
    repeat (8) begin
      step();
      if (sv_rd_en) bad++;
    end
    chk("en_off_no_pop", 32'(bad), 0);
    chk("en_off_drained", 32'(sv_valid), 0);
    chk("en_off_fifo_left", 32'(fq.size()), 11);
    chk("en_off_cnt", 32'(sv_cnt), 75);
    En = 1'b1;
    drain("en_resume", 100, 1'b0);
    chk("en_resume_cnt", 32'(sv_cnt), 86);
    chk("en_resume_fifo", 32'(fq.size()), 0);

    // 4-bit counter wraps after 17 words
    rem4 = 17;
    Fifo_empty4 = 1'b0;
    n = 0;
    step();
    while ((rem4 != 0 || sv_valid4) && n < 100) begin step(); n++; end
    step();
    chk("wrap_src_done", 32'(rem4), 0);
    chk("wrap_cnt4", 32'(sv_cnt4), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
